// File: rtl/acquire_pkg.sv
// Shared state encoding and default parameter values for the acquisition
// window controller and its start-bit filter.
package acquire_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_QUAL      = 2'd1,
    ST_ACQ       = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } acq_state_e;

  localparam int DEF_WAVE_W     = 16;
  localparam int DEF_CNT_W      = 19;
  localparam int DEF_WINDOW_LEN = 72162;
  localparam int DEF_FILT_LEN   = 4;
  localparam int DEF_REJ_W      = 8;

endpackage

// File: rtl/rx_start_filter.sv
// Synchronises the UART line into clk and flags the cycle in which the
// FILT_LEN-th consecutive low sample is seen while the controller listens.
module rx_start_filter
  import acquire_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_async,
  input  logic arm,
  output logic rx_s,
  output logic qual_low
);

  localparam int FCNT_W = $clog2(FILT_LEN + 1);
  localparam logic [FCNT_W-1:0] CNT_LAST = FCNT_W'(FILT_LEN - 1);
  localparam logic [FCNT_W-1:0] CNT_FULL = FCNT_W'(FILT_LEN);

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("rx_start_filter: FILT_LEN must be at least 1");
  end

  logic              sync1_r;
  logic              sync2_r;
  logic [FCNT_W-1:0] low_cnt_r;
  logic              low_s;

  assign low_s = arm & ~sync2_r;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_async;
      sync2_r <= sync1_r;
    end
  end

  // Run length of low samples; any high sample or disarm restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      low_cnt_r <= {FCNT_W{1'b0}};
    end else if (low_s && (low_cnt_r != CNT_FULL)) begin
      low_cnt_r <= low_cnt_r + FCNT_W'(1);
    end else if (low_s) begin
      low_cnt_r <= low_cnt_r;
    end else begin
      low_cnt_r <= {FCNT_W{1'b0}};
    end
  end

  assign rx_s     = sync2_r;
  assign qual_low = low_s & (low_cnt_r == CNT_LAST);

endmodule

// File: rtl/acquire_window_ctrl.sv
// Opens a fixed-length acquisition window on a qualified UART start bit,
// gated by waveform-number novelty unless free-running mode is selected.
module acquire_window_ctrl
  import acquire_pkg::*;
#(
  parameter int WAVE_W     = DEF_WAVE_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WINDOW_LEN = DEF_WINDOW_LEN,
  parameter int FILT_LEN   = DEF_FILT_LEN,
  parameter int REJ_W      = DEF_REJ_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              UART_RX,
  input  logic [WAVE_W-1:0] wavenum,
  input  logic              mode_free,
  input  logic              abort,
  output logic              acquire,
  output logic [CNT_W-1:0]  counter,
  output logic [WAVE_W-1:0] lastwavenum,
  output logic              done,
  output logic [REJ_W-1:0]  reject_cnt
);

  if (64'(WINDOW_LEN) > (64'd1 << CNT_W)) begin : g_cnt_w_too_small
    $error("acquire_window_ctrl: WINDOW_LEN does not fit in CNT_W bits");
  end
  if (WINDOW_LEN < 2) begin : g_window_too_short
    $error("acquire_window_ctrl: WINDOW_LEN must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WINDOW_LEN - 1);
  localparam logic [REJ_W-1:0] REJ_MAX    = {REJ_W{1'b1}};

  acq_state_e        state_r;
  acq_state_e        state_n;
  logic [CNT_W-1:0]  counter_r;
  logic [CNT_W-1:0]  counter_n;
  logic              acquire_r;
  logic              acquire_n;
  logic              done_r;
  logic              done_n;
  logic [WAVE_W-1:0] lastwave_r;
  logic [WAVE_W-1:0] lastwave_n;
  logic [REJ_W-1:0]  reject_r;
  logic [REJ_W-1:0]  reject_n;

  logic              rx_s;
  logic              qual_s;
  logic              arm_s;
  logic              accept_s;
  logic [REJ_W-1:0]  reject_inc_s;

  assign arm_s        = (state_r == ST_IDLE) || (state_r == ST_QUAL);
  assign accept_s     = mode_free || (wavenum != lastwave_r);
  assign reject_inc_s = (reject_r == REJ_MAX) ? reject_r : (reject_r + REJ_W'(1));

  rx_start_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_rx_start_filter (
    .clk      (clk),
    .reset    (reset),
    .rx_async (UART_RX),
    .arm      (arm_s),
    .rx_s     (rx_s),
    .qual_low (qual_s)
  );

  // Next-state and next-output decode; abort outranks terminal count in ACQ
  always_comb begin
    state_n    = state_r;
    counter_n  = {CNT_W{1'b0}};
    acquire_n  = 1'b1;
    done_n     = 1'b0;
    lastwave_n = lastwave_r;
    reject_n   = reject_r;
    case (state_r)
      ST_IDLE, ST_QUAL: begin
        if (qual_s) begin
          if (accept_s) begin
            state_n   = ST_ACQ;
            acquire_n = 1'b0;
          end else begin
            state_n  = ST_WAIT_HIGH;
            reject_n = reject_inc_s;
          end
        end else if (rx_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_QUAL;
        end
      end
      ST_ACQ: begin
        if (abort) begin
          state_n = ST_WAIT_HIGH;
        end else if (counter_r == LAST_COUNT) begin
          state_n    = ST_WAIT_HIGH;
          done_n     = 1'b1;
          lastwave_n = wavenum;
        end else begin
          counter_n = counter_r + CNT_W'(1);
          acquire_n = 1'b0;
        end
      end
      ST_WAIT_HIGH: begin
        // one trigger per low period: the line must go high before re-arming
        if (rx_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      counter_r  <= {CNT_W{1'b0}};
      acquire_r  <= 1'b1;
      done_r     <= 1'b0;
      lastwave_r <= {WAVE_W{1'b0}};
      reject_r   <= {REJ_W{1'b0}};
    end else begin
      state_r    <= state_n;
      counter_r  <= counter_n;
      acquire_r  <= acquire_n;
      done_r     <= done_n;
      lastwave_r <= lastwave_n;
      reject_r   <= reject_n;
    end
  end

  assign acquire     = acquire_r;
  assign counter     = counter_r;
  assign lastwavenum = lastwave_r;
  assign done        = done_r;
  assign reject_cnt  = reject_r;

endmodule

// File: tb/tb_acquire_window_ctrl.sv
// Directed scenarios plus randomized line activity, every cycle compared
// against a window/run-length reference model of the controller.
module tb_acquire_window_ctrl;

  localparam int WAVE_W     = 16;
  localparam int CNT_W      = 19;
  localparam int WINDOW_LEN = 10;
  localparam int FILT_LEN   = 4;
  localparam int REJ_W      = 8;
  localparam int REJ_MAX    = (1 << REJ_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              UART_RX;
  logic [WAVE_W-1:0] wavenum;
  logic              mode_free;
  logic              abort;
  logic              acquire;
  logic [CNT_W-1:0]  counter;
  logic [WAVE_W-1:0] lastwavenum;
  logic              done;
  logic [REJ_W-1:0]  reject_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int low_cycles = 0;
  int done_cnt   = 0;

  // reference model: line delay queue, open-window flag with elapsed cycles,
  // current low run length and a must-see-high-first flag
  int m_rx_q[$] = '{1, 1};
  bit m_open = 1'b0;
  bit m_need_high = 1'b0;
  bit m_done = 1'b0;
  int m_elapsed = 0;
  int m_low_run = 0;
  int m_rej = 0;
  int m_last = 0;

  always #5 clk = ~clk;

  acquire_window_ctrl #(
    .WAVE_W     (WAVE_W),
    .CNT_W      (CNT_W),
    .WINDOW_LEN (WINDOW_LEN),
    .FILT_LEN   (FILT_LEN),
    .REJ_W      (REJ_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .UART_RX     (UART_RX),
    .wavenum     (wavenum),
    .mode_free   (mode_free),
    .abort       (abort),
    .acquire     (acquire),
    .counter     (counter),
    .lastwavenum (lastwavenum),
    .done        (done),
    .reject_cnt  (reject_cnt)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int rxs;
    if (reset) begin
      m_rx_q = '{1, 1};
      m_open = 1'b0; m_need_high = 1'b0; m_done = 1'b0;
      m_elapsed = 0; m_low_run = 0; m_rej = 0; m_last = 0;
    end else begin
      rxs = m_rx_q.pop_front();
      m_rx_q.push_back(int'(UART_RX));
      m_done = 1'b0;
      if (m_open) begin
        if (abort) begin
          m_open = 1'b0; m_elapsed = 0; m_need_high = 1'b1;
        end else if (m_elapsed == WINDOW_LEN - 1) begin
          m_last = int'(wavenum); m_done = 1'b1;
          m_open = 1'b0; m_elapsed = 0; m_need_high = 1'b1;
        end else begin
          m_elapsed++;
        end
      end else if (m_need_high) begin
        if (rxs == 1) m_need_high = 1'b0;
      end else if (rxs == 1) begin
        m_low_run = 0;
      end else begin
        m_low_run++;
        if (m_low_run == FILT_LEN) begin
          m_low_run = 0;
          if (mode_free || (int'(wavenum) != m_last)) begin
            m_open = 1'b1; m_elapsed = 0;
          end else begin
            m_need_high = 1'b1;
            if (m_rej < REJ_MAX) m_rej++;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_val("acquire", acquire, !m_open);
    check_val("counter", counter, m_open ? m_elapsed : 0);
    check_val("done", done, m_done);
    check_val("lastwavenum", lastwavenum, m_last);
    check_val("reject_cnt", reject_cnt, m_rej);
    if (!acquire) low_cycles++;
    if (done) done_cnt++;
  endtask

  task automatic run_rx(input logic level, input int n);
    UART_RX = level;
    repeat (n) step();
  endtask

  task automatic wait_counter(input int target);
    bit hit = 1'b0;
    UART_RX = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (!acquire && (int'(counter) == target)) hit = 1'b1;
    end
    check_val("reach_counter", hit, 1);
  endtask

  initial begin
    reset = 1'b1; UART_RX = 1'b1; wavenum = '0; mode_free = 1'b0; abort = 1'b0;
    repeat (3) step();
    check_val("rst_acquire", acquire, 1);
    check_val("rst_counter", counter, 0);
    check_val("rst_done", done, 0);
    check_val("rst_reject", reject_cnt, 0);
    reset = 1'b0;

    // first window, line held low well past the window end
    wavenum = 16'd5; low_cycles = 0; done_cnt = 0;
    run_rx(1'b0, 20); run_rx(1'b1, 20);
    check_val("t1_low_cycles", low_cycles, 10);
    check_val("t1_done_pulses", done_cnt, 1);
    check_val("t1_lastwavenum", lastwavenum, 5);

    // same wavenum: refused, then free mode opens the window
    low_cycles = 0; done_cnt = 0;
    run_rx(1'b0, 10); run_rx(1'b1, 5);
    check_val("t2_no_window", low_cycles, 0);
    check_val("t2_reject", reject_cnt, 1);
    mode_free = 1'b1; low_cycles = 0;
    run_rx(1'b0, 20); run_rx(1'b1, 5);
    check_val("t2_free_window", low_cycles, 10);
    mode_free = 1'b0;

    // short glitch below the filter length
    low_cycles = 0;
    run_rx(1'b0, 3); run_rx(1'b1, 8);
    check_val("t3_glitch_window", low_cycles, 0);
    check_val("t3_glitch_reject", reject_cnt, 1);

    // abort mid-window and at terminal count
    wavenum = 16'd7;
    wait_counter(4);
    abort = 1'b1; step(); abort = 1'b0;
    check_val("abort4_acquire", acquire, 1);
    check_val("abort4_counter", counter, 0);
    check_val("abort4_done", done, 0);
    check_val("abort4_last", lastwavenum, 5);
    run_rx(1'b1, 5);
    done_cnt = 0;
    wait_counter(9);
    abort = 1'b1; step(); abort = 1'b0;
    run_rx(1'b1, 3);
    check_val("abort9_done", done_cnt, 0);
    check_val("abort9_last", lastwavenum, 5);

    // reset in the middle of a window
    run_rx(1'b1, 5);
    wavenum = 16'd9;
    wait_counter(6);
    reset = 1'b1; UART_RX = 1'b1; step(); reset = 1'b0;
    check_val("rstacq_acquire", acquire, 1);
    check_val("rstacq_counter", counter, 0);
    check_val("rstacq_last", lastwavenum, 0);
    check_val("rstacq_done", done, 0);
    check_val("rstacq_reject", reject_cnt, 0);

    // reject counter saturation
    wavenum = '0; low_cycles = 0;
    repeat (300) begin
      run_rx(1'b0, 5); run_rx(1'b1, 3);
    end
    check_val("sat_reject", reject_cnt, 255);
    check_val("sat_no_window", low_cycles, 0);

    // randomized line activity
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      len = $urandom_range(1, 24);
      UART_RX = ~UART_RX;
      if (!m_open && ($urandom_range(0, 2) == 0)) wavenum = WAVE_W'($urandom_range(0, 3));
      mode_free = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < len; k++) begin
        abort = ($urandom_range(0, 39) == 0);
        reset = ($urandom_range(0, 399) == 0);
        step();
      end
      abort = 1'b0; reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
